cpu_controller: RTL and testbench

Instruction register, decoder and control state machine for the simple RISC machine. It latches a 16-bit instruction, decodes it, and sequences the datapath's register-file, A/B/C register, shifter, mux, ALU and status enables over several cycles. It is the initiator side of the datapath control interface: every datapath control input is driven from here.

---
 rtl/cpu_controller_if.sv | 35 +++
 rtl/cpu_controller.sv | 174 +++++++++++++++++
 tb/tb_cpu_controller.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_controller_if.sv
// Controller <-> datapath control bundle for the simple RISC machine.
// master = controller (drives every datapath control), slave = datapath / instruction source.
interface cpu_controller_if;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic        err;
    logic [1:0]  wb_sel;
    logic [2:0]  w_addr;
    logic [2:0]  r_addr;
    logic        w_en;
    logic        en_A;
    logic        en_B;
    logic        en_C;
    logic        en_status;
    logic [1:0]  shift_op;
    logic        sel_A;
    logic        sel_B;
    logic [1:0]  ALU_op;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    modport master (
        input  in, load, s,
        output w, err, wb_sel, w_addr, r_addr, w_en, en_A, en_B, en_C, en_status,
               shift_op, sel_A, sel_B, ALU_op, sximm8, sximm5
    );

    modport slave (
        output in, load, s,
        input  w, err, wb_sel, w_addr, r_addr, w_en, en_A, en_B, en_C, en_status,
               shift_op, sel_A, sel_B, ALU_op, sximm8, sximm5
    );
endinterface

// File: rtl/cpu_controller.sv
// Instruction register, decoder and Moore control FSM for the simple RISC datapath.
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt in HALT with err=1 until reset.
module cpu_controller (
    input  logic              clk,
    input  logic              reset,
    cpu_controller_if.master  ctrl
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRIMM,
        S_GETA,
        S_GETB,
        S_ALU,
        S_WRREG
`ifdef CTRL_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    typedef enum logic [2:0] {
        K_MOVI,
        K_MOVR,
        K_ADD,
        K_CMP,
        K_AND,
        K_MVN,
        K_ILL
    } kind_t;

    typedef struct packed {
        logic       w;
        logic       err;
        logic [1:0] wb_sel;
        logic [2:0] w_addr;
        logic [2:0] r_addr;
        logic       w_en;
        logic       en_a;
        logic       en_b;
        logic       en_c;
        logic       en_status;
        logic [1:0] shift_op;
        logic       sel_a;
        logic [1:0] alu_op;
    } ctrl_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ctrl_t       ctrl_q, ctrl_d;

    // opc_op = {opcode, op} = IR[15:11]
    function automatic kind_t decode_kind(input logic [4:0] opc_op);
        kind_t k;
        case (opc_op)
            5'b110_10: k = K_MOVI;
            5'b110_00: k = K_MOVR;
            5'b101_00: k = K_ADD;
            5'b101_01: k = K_CMP;
            5'b101_10: k = K_AND;
            5'b101_11: k = K_MVN;
            default:   k = K_ILL;
        endcase
        return k;
    endfunction

    // Moore outputs for a state and the IR it operates on.
    function automatic ctrl_t moore_out(input state_t st, input logic [15:0] ir);
        ctrl_t o;
        kind_t k;
        k         = decode_kind(ir[15:11]);
        o         = '0;
        o.w       = (st == S_WAIT);
        o.alu_op  = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
        o.sel_a   = (k == K_MOVR);
        case (st)
            S_WRIMM: begin
                o.w_en   = 1'b1;
                o.wb_sel = 2'b10;
                o.w_addr = ir[10:8];
            end
            S_GETA: begin
                o.r_addr = ir[10:8];
                o.en_a   = 1'b1;
            end
            S_GETB: begin
                o.r_addr   = ir[2:0];
                o.en_b     = 1'b1;
                o.shift_op = ir[4:3];
            end
            S_ALU: begin
                o.shift_op  = ir[4:3];
                o.en_c      = (k != K_CMP);
                o.en_status = (k == K_CMP);
            end
            S_WRREG: begin
                o.w_en     = 1'b1;
                o.wb_sel   = 2'b00;
                o.w_addr   = ir[7:5];
                o.shift_op = ir[4:3];
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_HALT: o.err = 1'b1;
`endif
            default: ;
        endcase
        return o;
    endfunction

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (ctrl.load) ir_d = ctrl.in;
                if (ctrl.s)    state_d = S_DECODE;
            end
            S_DECODE: begin
                case (decode_kind(ir_q[15:11]))
                    K_MOVI:              state_d = S_WRIMM;
                    K_ADD, K_CMP, K_AND: state_d = S_GETA;
                    K_MOVR, K_MVN:       state_d = S_GETB;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:             state_d = S_HALT;
`else
                    default:             state_d = S_WAIT;
`endif
                endcase
            end
            S_GETA:  state_d = S_GETB;
            S_GETB:  state_d = S_ALU;
            S_ALU:   state_d = (decode_kind(ir_q[15:11]) == K_CMP) ? S_WAIT : S_WRREG;
            S_WRIMM: state_d = S_WAIT;
            S_WRREG: state_d = S_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_HALT:  state_d = S_HALT;
`endif
            default: state_d = S_WAIT;
        endcase
        // Outputs are registered: compute what the next state will present.
        ctrl_d = moore_out(state_d, ir_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
            ctrl_q  <= moore_out(S_WAIT, 16'h0000);
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Enables are masked by reset so nothing writes during the reset cycle itself.
    assign ctrl.w         = ctrl_q.w;
    assign ctrl.err       = ctrl_q.err;
    assign ctrl.wb_sel    = ctrl_q.wb_sel;
    assign ctrl.w_addr    = ctrl_q.w_addr;
    assign ctrl.r_addr    = ctrl_q.r_addr;
    assign ctrl.w_en      = ctrl_q.w_en      & ~reset;
    assign ctrl.en_A      = ctrl_q.en_a      & ~reset;
    assign ctrl.en_B      = ctrl_q.en_b      & ~reset;
    assign ctrl.en_C      = ctrl_q.en_c      & ~reset;
    assign ctrl.en_status = ctrl_q.en_status & ~reset;
    assign ctrl.shift_op  = ctrl_q.shift_op;
    assign ctrl.sel_A     = ctrl_q.sel_a;
    assign ctrl.sel_B     = 1'b0;
    assign ctrl.ALU_op    = ctrl_q.alu_op;
    assign ctrl.sximm8    = {{8{ir_q[7]}}, ir_q[7:0]};
    assign ctrl.sximm5    = {{11{ir_q[4]}}, ir_q[4:0]};

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized bench for cpu_controller against a per-instruction schedule model.
module tb_cpu_controller;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cpu_controller_if bus ();

    cpu_controller dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    // Observed control word; enables occupy bits [10:6].
    wire [31:0] obs = {11'b0, bus.w, bus.err, bus.wb_sel, bus.w_addr, bus.r_addr,
                       bus.w_en, bus.en_A, bus.en_B, bus.en_C, bus.en_status,
                       bus.shift_op, bus.sel_A, bus.sel_B, bus.ALU_op};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Cycle-by-cycle phase list after the start edge:
    // D=decode, I=write imm, A=read Rn, B=read Rm, L=ALU, R=write Rd, W=idle, H=halted.
    function automatic string sched(input logic [15:0] i);
        int opc = int'(i[15:13]);
        int op  = int'(i[12:11]);
        if (opc == 6 && op == 2) return "DIW";
        if (opc == 6 && op == 0) return "DBLRW";
        if (opc == 5 && op == 1) return "DABLW";
        if (opc == 5 && op == 3) return "DBLRW";
        if (opc == 5)            return "DABLRW";
`ifdef CTRL_ILLEGAL_TRAP_EN
        return "DHHH";
`else
        return "DW";
`endif
    endfunction

    function automatic logic [31:0] model(input logic [15:0] i, input byte ph);
        logic       is_cmp  = (i[15:13] == 3'd5) && (i[12:11] == 2'd1);
        logic       is_movr = (i[15:13] == 3'd6) && (i[12:11] == 2'd0);
        logic       w_b     = (ph == "W");
        logic       err_b   = (ph == "H");
        logic [1:0] wbs     = (ph == "I") ? 2'b10 : 2'b00;
        logic [2:0] wa      = (ph == "I") ? i[10:8] : (ph == "R") ? i[7:5] : 3'd0;
        logic [2:0] ra      = (ph == "A") ? i[10:8] : (ph == "B") ? i[2:0] : 3'd0;
        logic       we      = (ph == "I") || (ph == "R");
        logic       ea      = (ph == "A");
        logic       eb      = (ph == "B");
        logic       ec      = (ph == "L") && !is_cmp;
        logic       es      = (ph == "L") && is_cmp;
        logic [1:0] sh      = (ph == "B" || ph == "L" || ph == "R") ? i[4:3] : 2'd0;
        logic [1:0] aop     = (i[15:13] == 3'd5) ? i[12:11] : 2'd0;
        return {11'b0, w_b, err_b, wbs, wa, ra, we, ea, eb, ec, es, sh, is_movr, 1'b0, aop};
    endfunction

    function automatic logic [15:0] sext(input logic [15:0] i, input int bits);
        int v = int'(i) % (1 << bits);
        if (v >= (1 << (bits - 1))) v = v - (1 << bits);
        return 16'(v);
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        bus.in   = 16'h0;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_word", obs, model(16'h0, "W"));
        chk("reset_ir", {16'h0, bus.sximm8}, 32'h0);
    endtask

    // Starts at a negedge in WAIT; ends at a negedge in WAIT (or HALT).
    task automatic run(input logic [15:0] instr, input int abort_at);
        string sc = sched(instr);
        byte   ph;
        bus.in   = instr;
        bus.load = 1'b1;
        bus.s    = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= sc.len(); c++) begin
            @(negedge clk);
            ph = sc[c-1];
            if (c == abort_at) begin
                reset    = 1'b1;
                bus.load = 1'b0;
                bus.s    = 1'b0;
                #1;
                chk($sformatf("abort_en %h c%0d", instr, c), {27'b0, obs[10:6]}, 32'h0);
                @(negedge clk);
                reset = 1'b0;
                chk($sformatf("abort_wait %h", instr), obs, model(16'h0, "W"));
                chk($sformatf("abort_ir %h", instr), {16'h0, bus.sximm8}, 32'h0);
                return;
            end
            chk($sformatf("%h c%0d", instr, c), obs, model(instr, ph));
            if (c == 1)
                chk($sformatf("%h sximm", instr), {bus.sximm8, bus.sximm5},
                    {sext(instr, 8), sext(instr, 5)});
            if (ph != "W") begin
                bus.in   = 16'($urandom);
                bus.load = 1'($urandom);
                bus.s    = 1'($urandom);
            end else begin
                bus.load = 1'b0;
                bus.s    = 1'b0;
            end
        end
        if (sc[sc.len()-1] == "H") do_reset();
    endtask

    logic [15:0] directed [7] = '{16'hD007, 16'hD1FE, 16'hA148, 16'hA900,
                                  16'hB860, 16'hC080, 16'hE000};
    logic [4:0]  legal    [6] = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111};

    initial begin
        logic [15:0] instr;
        int          ab;
        reset    = 1'b1;
        bus.in   = 16'h0;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        do_reset();
        foreach (directed[k]) run(directed[k], 0);
        run(16'hA148, 4);
        for (int n = 0; n < 80; n++) begin
            instr = 16'($urandom);
            if ($urandom_range(0, 9) < 8) instr[15:11] = legal[$urandom_range(0, 5)];
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, sched(instr).len()) : 0;
            run(instr, ab);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
